// File: rtl/lsu_access_ctrl.sv
// Load/store initiator: one request at a time, misaligned half/word split into byte beats.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned requests instead of splitting them.
module lsu_access_ctrl #(
  parameter int ADDR_W = 20,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_memop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_memop,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam logic [1:0] WLAST = 2'(RD_LAT - 1);

  state_t            state;
  logic              we_q;
  logic [2:0]        memop_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic              split_q;
  logic [2:0]        nbeats_q;
  logic [2:0]        i_q;
  logic [1:0]        wcnt_q;
  logic [31:0]       asm_q;

  logic              illegal;
  logic              misal;
  logic              trap;
  logic [2:0]        i_nxt;
  logic              last;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        next_byte;
  logic [31:0]       asm_nxt;
  logic [31:0]       ext_val;

  always_comb begin
    illegal = (req_memop == 3'b011)
           || (req_memop[2:1] == 2'b11)
           || (req_we && req_memop[2]);
    misal = (req_memop[1:0] == 2'b01 && req_addr[0])
         || (req_memop[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misal;
`else
  assign trap = 1'b0;
`endif

  assign i_nxt     = i_q + 3'd1;
  assign last      = (i_nxt == nbeats_q);
  assign next_addr = base_q + ADDR_W'(i_nxt);
  assign next_byte = wdata_q[{i_nxt[1:0], 3'b000} +: 8];

  // Byte lane i is filled from the low byte of each split read beat
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{i_q[1:0], 3'b000} +: 8] = mem_rdata[7:0];
    case (memop_q)
      3'b001:  ext_val = {{16{asm_nxt[15]}}, asm_nxt[15:0]};
      3'b101:  ext_val = {16'b0, asm_nxt[15:0]};
      default: ext_val = asm_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_memop  <= 3'b000;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      memop_q    <= 3'b000;
      base_q     <= '0;
      wdata_q    <= '0;
      split_q    <= 1'b0;
      nbeats_q   <= 3'd1;
      i_q        <= 3'd0;
      wcnt_q     <= 2'd0;
      asm_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            memop_q    <= req_memop;
            base_q     <= req_addr;
            wdata_q    <= req_wdata;
            asm_q      <= '0;
            i_q        <= 3'd0;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (illegal || trap) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state    <= ISSUE;
              split_q  <= misal;
              mem_addr <= req_addr;
              mem_we   <= req_we;
              if (misal) begin
                nbeats_q  <= (req_memop[1:0] == 2'b01) ? 3'd2 : 3'd4;
                mem_memop <= req_we ? 3'b000 : 3'b100;
                mem_wdata <= {24'b0, req_wdata[7:0]};
              end else begin
                nbeats_q  <= 3'd1;
                mem_memop <= req_memop;
                mem_wdata <= req_wdata;
              end
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            if (last) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= 1'b0;
            end else begin
              i_q       <= i_nxt;
              mem_addr  <= next_addr;
              mem_wdata <= {24'b0, next_byte};
              mem_we    <= 1'b1;
            end
          end else begin
            state  <= WAIT;
            wcnt_q <= 2'd0;
          end
        end
        WAIT: begin
          if (wcnt_q == WLAST) begin
            asm_q <= asm_nxt;
            if (!split_q || last) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= split_q ? ext_val : mem_rdata;
            end else begin
              state    <= ISSUE;
              i_q      <= i_nxt;
              mem_addr <= next_addr;
            end
          end else begin
            wcnt_q <= wcnt_q + 2'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
- CPU-side load/store initiator that drives the data-memory port: addr, memop, we, datain; receives dataout.
- Accepts one request at a time from the pipeline over a valid/ready handshake, issues the memory beats, and returns one response.
- Aligned accesses go out as a single native beat.
- Misaligned halfword/word accesses are split into byte beats and reassembled little-endian, then sign- or zero-extended per the original memop.

Parameters:
- ADDR_W, 20, byte-address width of request and memory port.
- RD_LAT, 1, clocks from a read beat's issue edge to dataout valid (1..3).

Ports:
- clk  in  1  single clock; memory rdclk/wrclk are tied to it.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_memop  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse on completion.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid.
- mem_addr  out  ADDR_W  to memory addr.
- mem_memop  out  3  to memory memop.
- mem_we  out  1  to memory we.
- mem_wdata  out  32  to memory datain, right-justified.
- mem_rdata  in  32  from memory dataout, already lane-shifted and extended by the memory.

Behaviour:
- Reset, async, immediate:
  - State goes to IDLE.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - mem_addr=0; mem_memop=000; mem_we=0; mem_wdata=0.
  - Reset mid-operation abandons the access; mem_we drops asynchronously, no response is issued, and no partial write continues.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on req_valid&&req_ready, latch we/memop/addr/wdata, clear the byte-assembly register, set i=0.
  - Illegal request (memop 011/110/111, or store with 100/101): go to RESP with resp_err=1. No memory beat is issued.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0): nbeats = size in bytes (2 or 4). Beat memop is 000 for stores, 100 for loads.
  - Aligned request: nbeats=1, beat memop = request memop.
- ISSUE: drive mem_addr = base+i, modulo 2^ADDR_W (the top address wraps to 0), and mem_memop = beat memop.
  - Single beat: mem_wdata = wdata.
  - Split beat: mem_wdata = {24'b0, wdata byte i}.
  - Store: mem_we=1 for exactly this cycle. Increment i; when i reaches nbeats, go to RESP, else stay in ISSUE.
  - Load: mem_we=0; go to WAIT.
- WAIT: hold mem_addr and mem_memop; count RD_LAT cycles.
  - On the final WAIT cycle, capture mem_rdata: the whole word for a single beat, or bits [7:0] into byte lane i for a split.
  - Then return to ISSUE for the next beat, or go to RESP.
- RESP: resp_valid=1 for one cycle.
  - Split loads: resp_rdata is the assembled value, sign-extended from bit 7/15 for 000/001, zero-extended for 100/101.
  - Single-beat loads: resp_rdata is passed through.
  - Next state is IDLE.
- req_ready=0 in ISSUE/WAIT/RESP. req_valid is ignored while busy; the requester holds it.
- Latency, request edge to resp_valid (accept edge is cycle 0, resp_valid in cycle N):
  - Aligned store: N=2.
  - Aligned load: N=2+RD_LAT.
  - Split store: N=1+nbeats.
  - Split load: N=1+nbeats*(1+RD_LAT).
  - Error: N=1.
- Outside ISSUE/WAIT: mem_we=0; mem_addr/memop hold their last values.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests are not split. They go IDLE->RESP with resp_err=1 and resp_rdata=0, no memory beat, latency 1.
- Undefined: splitting as specified above.

Test Plan:
- Store sw addr=0x00010 wdata=0xDEADBEEF, then lw 0x00010 -> one beat each, mem_memop=010; load resp_rdata=0xDEADBEEF at cycle 3 (RD_LAT=1), resp_err=0.
- Preload word 0x00020=0x8899AABB; lh addr=0x00022 -> resp_rdata=0xFFFF8899; lhu -> 0x00008899.
- Preload 0x00030=0x44332211 and 0x00034=0x88776655; lw addr=0x00031 -> 4 byte beats at 0x31..0x34, resp_rdata=0x55443322, resp_valid at cycle 9.
- sh addr=0x00043 wdata=0x0000CAFE -> byte writes 0xFE@0x43 then 0xCA@0x44, each mem_we pulse one cycle; lw of 0x40 and 0x44 confirm the bytes and that neighbouring bytes are unchanged.
- memop=011 load, and store with memop=101 -> resp_err=1 at cycle 1, mem_we never asserted; lw at 0xFFFFD -> beats wrap to 0x00000.
- Assert rst during the 2nd beat of a split store -> mem_we=0 immediately, req_ready=1 after release, no resp_valid; with LSU_MISALIGN_TRAP_EN, lh addr=0x00001 -> resp_err=1 at cycle 1, no beat.
